eth_frame_rx: RTL and testbench
===============================

# eth_frame_rx

Ethernet receive framer sitting directly downstream of the MII nibble-to-byte assembler, in the `mii_clk` domain. It consumes the assembled byte strobe/data plus the raw MII enable, strips preamble and SFD, forwards frame bytes with start/end markers, and checks each frame's FCS. At the end of every frame it emits one status pulse carrying the frame length, CRC result and runt/giant flags.

## Interface
- `MIN_PREAMBLE`, 2: minimum count of 0x55 bytes required before 0xD5 (SFD) is accepted.
- `MAX_LEN`, 1518: largest legal frame length in bytes, FCS included.
- `mii_clk`  in  1  receive clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `frame_en`  in  1  raw MII enable (RX_DV), same cycle as it is presented to the assembler.
- `byte_rdy`  in  1  one-cycle strobe from the assembler: `byte_d` holds a new byte.
- `byte_d`  in  8  assembled byte.
- `m_valid`  out  1  one-cycle strobe, frame byte on `m_data`.
- `m_data`  out  8  frame byte (destination MAC through FCS).
- `m_sof`  out  1  with `m_valid`, first byte after SFD.
- `m_eof`  out  1  one-cycle end-of-frame marker; see Timing.
- `stat_valid`  out  1  one-cycle status strobe, once per frame that reached DATA.
- `stat_len`  out  11  byte count after SFD, FCS included, saturating at 2047.
- `stat_crc_err`  out  1  FCS residue mismatch.
- `stat_runt`  out  1  `stat_len` < 64.
- `stat_giant`  out  1  `stat_len` > `MAX_LEN`.

## Operation
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: on `byte_rdy` with `frame_en`=1: 0x55 -> PREAMBLE, preamble count = 1; any other byte -> DROP. `frame_en`=0 is ignored here.
- PREAMBLE: 0x55 increments count, saturating at 7. 0xD5 with count >= `MIN_PREAMBLE` -> DATA; the CRC register is set to 0xFFFFFFFF and the length counter is set to 0. 0xD5 with a short count, or any other byte -> DROP.
- DATA: each strobed byte is forwarded, the length counter is incremented, and the CRC is updated.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, processed LSB first over every byte after the SFD, FCS included. A good frame leaves the residue 0xDEBB20E3. Any other residue sets `stat_crc_err`=1.
- Frame close: the first cycle in PREAMBLE, DATA or DROP with `frame_en`=0 is the closing cycle C.
  - A `byte_rdy` in cycle C is still processed as part of the frame, because the assembler delivers the final byte after the enable drops.
  - After cycle C the block returns to IDLE.
- Only frames that reached DATA produce status. Closing from PREAMBLE or DROP is silent.
- A frame that closes with zero DATA bytes reports `stat_len`=0, `stat_runt`=1, `stat_crc_err`=1.
- No backpressure: downstream must accept every `m_valid`.

## Timing
- Reset: state goes to IDLE. All outputs are 0: `m_valid`, `m_data`, `m_sof`, `m_eof`, `stat_*`. Internal counters and CRC are cleared.
- Reset mid-frame: the partial frame is discarded with no `m_eof` and no `stat_valid`. If `frame_en` is still high after reset, the following bytes go through IDLE and normally land in DROP.
- Byte latency: `byte_rdy` at cycle N -> `m_valid`/`m_data` at N+1. `m_sof` is set only on the first DATA byte.
- End of frame: `m_eof` and `stat_valid` are both asserted at C+1, for one cycle.
  - If a byte arrived in cycle C, it appears at C+1 with `m_valid`=1 and `m_eof`=1 together.
  - If no byte arrived in cycle C, `m_eof` is asserted at C+1 with `m_valid`=0.
- Status values at C+1 include any byte strobed in cycle C. The residue comparison uses the updated CRC.
- Back-to-back frames: `frame_en` may go high again at C+1. A `byte_rdy` at C+1 is handled from IDLE.
- Length counter saturates at 2047 and never wraps; `stat_giant` stays asserted.
- `stat_*` fields hold their values until the next `stat_valid`. `m_data` holds its value until the next `m_valid`.

## Test plan
- Frame with 7×0x55, 0xD5, then ASCII "123456789", then FCS bytes 26 39 F4 CB, with `frame_en` dropping in the same cycle as the last `byte_rdy`.
  - 13 `m_valid` pulses; `m_sof` on 0x31, `m_eof` on 0xCB.
  - `stat_len`=13, `stat_crc_err`=0, `stat_runt`=1, `stat_giant`=0.
- Same frame with the last FCS byte changed to 0xCA -> `stat_crc_err`=1, `stat_len`=13.
- Preamble of a single 0x55, then 0xD5 -> DROP. No `m_valid`, no `stat_valid`; the block returns to IDLE when `frame_en` goes low.
- 64-byte good frame followed immediately by a 1519-byte good frame.
  - First frame: `stat_runt`=0, `stat_giant`=0.
  - Second frame: `stat_len`=1519, `stat_giant`=1.
  - The second SOF is detected with no gap cycles.
- `reset`=0 for one cycle after DATA byte 20 -> no `m_eof` and no `stat_valid` for that frame. A new good frame after `frame_en` deasserts is received correctly.
- `frame_en` low in DATA with no `byte_rdy` in that cycle -> at C+1, `m_eof`=1 with `m_valid`=0, and `stat_valid`=1.

Source files
------------

// File: rtl/eth_frame_rx.sv
// Receive framer: strips the preamble and SFD, forwards frame bytes with start/end markers,
// checks the FCS residue and emits one status pulse per frame that reached DATA.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | between frames, waiting for the first 0x55 with frame_en
// S_PRE    | counting 0x55 preamble bytes, waiting for the SFD
// S_DATA   | forwarding frame bytes, updating length and CRC
// S_DROP   | malformed start, discarding until frame_en drops
module eth_frame_rx #(
  parameter int MIN_PREAMBLE = 2,
  parameter int MAX_LEN      = 1518
) (
  input  logic        mii_clk,
  input  logic        reset,
  input  logic        frame_en,
  input  logic        byte_rdy,
  input  logic [7:0]  byte_d,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_sof,
  output logic        m_eof,
  output logic        stat_valid,
  output logic [10:0] stat_len,
  output logic        stat_crc_err,
  output logic        stat_runt,
  output logic        stat_giant
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_PRE  = 2'd1;
  localparam logic [1:0]  S_DATA = 2'd2;
  localparam logic [1:0]  S_DROP = 2'd3;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [2:0]  MIN_PRE_C   = 3'(MIN_PREAMBLE);
  localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
  localparam logic [10:0] RUNT_LEN    = 11'd64;

  logic [1:0]  state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic        sof_pend_q, sof_pend_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_sof_q, m_sof_d;
  logic        m_eof_q, m_eof_d;
  logic        stat_valid_q, stat_valid_d;
  logic [10:0] stat_len_q, stat_len_d;
  logic        stat_crc_err_q, stat_crc_err_d;
  logic        stat_runt_q, stat_runt_d;
  logic        stat_giant_q, stat_giant_d;

  // Reflected CRC-32, one byte LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    len_d          = len_q;
    crc_d          = crc_q;
    sof_pend_d     = sof_pend_q;
    m_valid_d      = 1'b0;
    m_data_d       = m_data_q;
    m_sof_d        = 1'b0;
    m_eof_d        = 1'b0;
    stat_valid_d   = 1'b0;
    stat_len_d     = stat_len_q;
    stat_crc_err_d = stat_crc_err_q;
    stat_runt_d    = stat_runt_q;
    stat_giant_d   = stat_giant_q;

    case (state_q)
      S_IDLE: begin
        if (byte_rdy && frame_en) begin
          if (byte_d == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (byte_rdy) begin
          if (byte_d == 8'h55) begin
            if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
          end else if (byte_d == 8'hD5 && pre_cnt_q >= MIN_PRE_C) begin
            state_d    = S_DATA;
            crc_d      = 32'hFFFFFFFF;
            len_d      = 11'd0;
            sof_pend_d = 1'b1;
          end else begin
            state_d = S_DROP;
          end
        end
        // An SFD in the closing cycle has no data behind it, so the frame ends silently.
        if (!frame_en) state_d = S_IDLE;
      end
      S_DATA: begin
        if (byte_rdy) begin
          m_valid_d  = 1'b1;
          m_data_d   = byte_d;
          m_sof_d    = sof_pend_q;
          sof_pend_d = 1'b0;
          len_d      = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
          crc_d      = crc_byte(crc_q, byte_d);
        end
        // Status uses the values already updated by a byte landing in the closing cycle.
        if (!frame_en) begin
          state_d        = S_IDLE;
          m_eof_d        = 1'b1;
          stat_valid_d   = 1'b1;
          stat_len_d     = len_d;
          stat_crc_err_d = (crc_d != CRC_RESIDUE);
          stat_runt_d    = (len_d < RUNT_LEN);
          stat_giant_d   = (len_d > MAX_LEN_C);
        end
      end
      default: begin
        if (!frame_en) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mii_clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      pre_cnt_q      <= 3'd0;
      len_q          <= 11'd0;
      crc_q          <= 32'd0;
      sof_pend_q     <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= 8'd0;
      m_sof_q        <= 1'b0;
      m_eof_q        <= 1'b0;
      stat_valid_q   <= 1'b0;
      stat_len_q     <= 11'd0;
      stat_crc_err_q <= 1'b0;
      stat_runt_q    <= 1'b0;
      stat_giant_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      len_q          <= len_d;
      crc_q          <= crc_d;
      sof_pend_q     <= sof_pend_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_sof_q        <= m_sof_d;
      m_eof_q        <= m_eof_d;
      stat_valid_q   <= stat_valid_d;
      stat_len_q     <= stat_len_d;
      stat_crc_err_q <= stat_crc_err_d;
      stat_runt_q    <= stat_runt_d;
      stat_giant_q   <= stat_giant_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_sof        = m_sof_q;
  assign m_eof        = m_eof_q;
  assign stat_valid   = stat_valid_q;
  assign stat_len     = stat_len_q;
  assign stat_crc_err = stat_crc_err_q;
  assign stat_runt    = stat_runt_q;
  assign stat_giant   = stat_giant_q;

endmodule

// File: tb/tb_eth_frame_rx.sv
// Bench for eth_frame_rx: table of frame shapes with hand-derived status, hand sequences
// for back-to-back and mid-frame reset, then random frames checked against a frame-level model.
module tb_eth_frame_rx;

  logic        mii_clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_en = 1'b0;
  logic        byte_rdy = 1'b0;
  logic [7:0]  byte_d = 8'h00;
  logic        m_valid, m_sof, m_eof, stat_valid, stat_crc_err, stat_runt, stat_giant;
  logic [7:0]  m_data;
  logic [10:0] stat_len;

  eth_frame_rx #(.MIN_PREAMBLE(2), .MAX_LEN(1518)) dut (
    .mii_clk(mii_clk), .reset(reset), .frame_en(frame_en), .byte_rdy(byte_rdy),
    .byte_d(byte_d), .m_valid(m_valid), .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof),
    .stat_valid(stat_valid), .stat_len(stat_len), .stat_crc_err(stat_crc_err),
    .stat_runt(stat_runt), .stat_giant(stat_giant)
  );

  always #5 mii_clk = ~mii_clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { bit valid; logic [7:0] data; bit sof; bit eof; bit stat; } ev_t;
  typedef struct { logic [10:0] len; bit err; bit runt; bit giant; } st_t;
  typedef struct {
    int n_pre; logic [7:0] sfd; bit lit; int body_len; int fcs_mode; bit last_in_c;
    bit exp_stat; int exp_len; bit exp_err; bit exp_runt; bit exp_giant;
  } vec_t;

  ev_t  got_ev[$], exp_ev[$];
  st_t  got_st[$], exp_st[$];
  vec_t vt[$];
  int   tests = 0;
  int   fails = 0;

  always @(negedge mii_clk) begin
    if (m_valid || m_eof || stat_valid)
      got_ev.push_back('{m_valid, m_data, m_sof, m_eof, stat_valid});
    if (stat_valid)
      got_st.push_back('{stat_len, stat_crc_err, stat_runt, stat_giant});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit en, input bit rdy, input logic [7:0] d);
    frame_en = en;
    byte_rdy = rdy;
    byte_d   = d;
    @(posedge mii_clk);
    #1;
  endtask

  // Standard Ethernet CRC-32 (final inversion applied) over the first n bytes.
  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t build(input int n_pre, input logic [7:0] sfd, input bit lit,
                                input int body_len, input int fcs_mode);
    bq_t q, body;
    logic [31:0] f;
    if (lit) begin
      for (int i = 0; i < 9; i++) body.push_back(8'h31 + 8'(i));
      body.push_back(8'h26); body.push_back(8'h39); body.push_back(8'hF4);
      body.push_back(fcs_mode == 1 ? 8'hCA : 8'hCB);
    end else begin
      for (int i = 0; i < body_len; i++) body.push_back(8'($urandom));
      if (fcs_mode != 2) begin
        f = crc32(body, body.size());
        if (fcs_mode == 1) f = f ^ 32'h0000_0100;
        for (int i = 0; i < 4; i++) body.push_back(f[8*i +: 8]);
      end
    end
    for (int i = 0; i < n_pre; i++) q.push_back(8'h55);
    q.push_back(sfd);
    foreach (body[i]) q.push_back(body[i]);
    return q;
  endfunction

  // Frame-level model: locate the SFD after the 0x55 run, then derive stream and status.
  task automatic model(input bq_t q, input bit last_in_c, output bit has_stat, output st_t st);
    int k, n;
    bq_t body;
    logic [31:0] fcs;
    k = 0;
    while (k < q.size() && q[k] == 8'h55) k++;
    has_stat = (k >= 2) && (k < q.size()) && (q[k] == 8'hD5);
    st = '{11'd0, 1'b1, 1'b1, 1'b0};
    if (has_stat) begin
      for (int i = k + 1; i < q.size(); i++) body.push_back(q[i]);
      n = body.size();
      for (int i = 0; i < n; i++) begin
        exp_ev.push_back('{1'b1, body[i], i == 0, last_in_c && i == n - 1, last_in_c && i == n - 1});
      end
      if (!last_in_c) exp_ev.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
      st.len = (n > 2047) ? 11'd2047 : 11'(n);
      if (n >= 4) begin
        fcs = {body[n-1], body[n-2], body[n-3], body[n-4]};
        st.err = (crc32(body, n - 4) != fcs);
      end
      st.runt  = (n < 64);
      st.giant = (n > 1518);
    end
  endtask

  task automatic send(input bq_t q, input bit last_in_c);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, 1)) cyc(1'b1, 1'b0, 8'h00);
      cyc(!(last_in_c && i == q.size() - 1), 1'b1, q[i]);
    end
    if (!last_in_c) cyc(1'b0, 1'b0, 8'h00);
    frame_en = 1'b0;
    byte_rdy = 1'b0;
  endtask

  task automatic check_all(input string name);
    int n;
    ev_t g, e;
    st_t gs, es;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check($sformatf("%s ev_count", name), got_ev.size(), exp_ev.size());
    n = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
    for (int i = 0; i < n; i++) begin
      g = got_ev[i];
      e = exp_ev[i];
      check($sformatf("%s ev%0d {valid,sof,eof,stat,data}", name, i),
            {g.valid, g.sof, g.eof, g.stat, (g.valid ? g.data : 8'h00)},
            {e.valid, e.sof, e.eof, e.stat, e.data});
    end
    check($sformatf("%s stat_count", name), got_st.size(), exp_st.size());
    n = (got_st.size() < exp_st.size()) ? got_st.size() : exp_st.size();
    for (int i = 0; i < n; i++) begin
      gs = got_st[i];
      es = exp_st[i];
      check($sformatf("%s stat%0d {len,err,runt,giant}", name, i),
            {gs.len, gs.err, gs.runt, gs.giant}, {es.len, es.err, es.runt, es.giant});
    end
    got_ev.delete(); exp_ev.delete(); got_st.delete(); exp_st.delete();
  endtask

  initial begin
    bq_t  q, q2;
    bit   hs, lc;
    st_t  st;
    int   npre, blen, fm;
    logic [7:0] sfd;

    //            pre sfd    lit len   fcs lastC stat len   err runt giant
    vt.push_back('{7, 8'hD5, 1, 0,    0, 1, 1, 13,   0, 1, 0});
    vt.push_back('{7, 8'hD5, 1, 0,    1, 1, 1, 13,   1, 1, 0});
    vt.push_back('{1, 8'hD5, 0, 10,   0, 0, 0, 0,    0, 0, 0});
    vt.push_back('{3, 8'h5D, 0, 10,   0, 1, 0, 0,    0, 0, 0});
    vt.push_back('{0, 8'hD5, 0, 10,   0, 1, 0, 0,    0, 0, 0});
    vt.push_back('{2, 8'hD5, 0, 10,   0, 0, 1, 14,   0, 1, 0});
    vt.push_back('{7, 8'hD5, 0, 60,   0, 1, 1, 64,   0, 0, 0});
    vt.push_back('{7, 8'hD5, 0, 1514, 0, 1, 1, 1518, 0, 0, 0});
    vt.push_back('{7, 8'hD5, 0, 1515, 0, 0, 1, 1519, 0, 0, 1});
    vt.push_back('{7, 8'hD5, 0, 0,    2, 0, 1, 0,    1, 1, 0});
    vt.push_back('{7, 8'hD5, 0, 2100, 0, 1, 1, 2047, 0, 0, 1});
    vt.push_back('{7, 8'hD5, 0, 20,   1, 1, 1, 24,   1, 1, 0});
    vt.push_back('{9, 8'hD5, 0, 40,   0, 1, 1, 44,   0, 1, 0});

    reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    check("reset_outputs",
          {m_valid, m_data, m_sof, m_eof, stat_valid, stat_len, stat_crc_err, stat_runt, stat_giant},
          32'h0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);

    foreach (vt[r]) begin
      q = build(vt[r].n_pre, vt[r].sfd, vt[r].lit, vt[r].body_len, vt[r].fcs_mode);
      model(q, vt[r].last_in_c, hs, st);
      if (vt[r].exp_stat)
        exp_st.push_back('{11'(vt[r].exp_len), vt[r].exp_err, vt[r].exp_runt, vt[r].exp_giant});
      send(q, vt[r].last_in_c);
      check_all($sformatf("vec%0d", r));
    end

    // 64-byte then 1519-byte frame, second preamble starts the cycle after the first closes.
    q  = build(7, 8'hD5, 0, 60, 0);
    q2 = build(7, 8'hD5, 0, 1515, 0);
    model(q, 1'b1, hs, st);
    model(q2, 1'b1, hs, st);
    exp_st.push_back('{11'd64, 1'b0, 1'b0, 1'b0});
    exp_st.push_back('{11'd1519, 1'b0, 1'b0, 1'b1});
    send(q, 1'b1);
    send(q2, 1'b1);
    check_all("back_to_back");

    // Reset pulse after DATA byte 20: no end marker or status for that frame.
    q = build(7, 8'hD5, 0, 30, 0);
    for (int i = 0; i < 28; i++) cyc(1'b1, 1'b1, q[i]);
    for (int i = 0; i < 20; i++) exp_ev.push_back('{1'b1, q[8+i], i == 0, 1'b0, 1'b0});
    reset = 1'b0;
    cyc(1'b1, 1'b0, 8'h00);
    reset = 1'b1;
    check("midframe_reset_outputs",
          {m_valid, m_data, m_sof, m_eof, stat_valid, stat_len, stat_crc_err, stat_runt, stat_giant},
          32'h0);
    cyc(1'b1, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h12);
    cyc(1'b0, 1'b0, 8'h00);
    q = build(7, 8'hD5, 0, 50, 0);
    model(q, 1'b1, hs, st);
    exp_st.push_back('{11'd54, 1'b0, 1'b1, 1'b0});
    send(q, 1'b1);
    check_all("reset_midframe");

    // Random frames with idle gaps that may carry strobes while frame_en is low.
    for (int r = 0; r < 40; r++) begin
      npre = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 8));
      sfd  = ($urandom_range(0, 7) == 0) ? 8'h5D : 8'hD5;
      blen = $urandom_range(0, 80);
      fm   = $urandom_range(0, 2);
      lc   = (blen == 0 && fm == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      q = build(npre, sfd, 1'b0, blen, fm);
      model(q, lc, hs, st);
      if (hs) exp_st.push_back(st);
      send(q, lc);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    check_all("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
